cap_scan_sched: RTL and testbench
=================================

Name: cap_scan_sched

Overview:
- Time-multiplexed capacitive-touch scanner for N_CH pads sharing one measurement counter.
- Per channel: grounds the pad, releases it, then counts cycles until the external pull-up charges it above threshold.
- Compares each count against a per-channel baseline and debounces the result into per-pad touch flags.
- Sits between the uio pad drivers and the top-level outputs; scales the single-pad touch sensor to a multi-pad scanner.

Parameters:
- N_CH, 4: number of pads scanned (1..8).
- CNT_W, 12: measurement counter width.
- DISCHARGE_CYC, 16: cycles a pad is held low before release (>=2).
- TIMEOUT, 4095: measurement saturation count (<= 2^CNT_W-1).
- THRESH, 40: count delta over baseline that signals touch; release level is THRESH/2 (floor).
- DEB_N, 3: consecutive agreeing scans required to change a touch flag.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run scanning; sampled at channel boundaries.
- cap_in  in  N_CH  raw pad levels (asynchronous).
- cap_out  out  N_CH  pad drive value; constant 0.
- cap_oe  out  N_CH  pad output enable; 1 = grounded, 0 = released.
- touch  out  N_CH  debounced touch flags.
- sample_valid  out  1  one-cycle pulse, measurement complete.
- sample_ch  out  $clog2(N_CH) (min 1)  channel of the current sample.
- sample_cnt  out  CNT_W  raw count of the current sample.

Behaviour:
- Reset: state IDLE; ch=0; cap_oe all 1s; cap_out 0; touch 0; sample_valid 0; sample_ch 0; sample_cnt 0; baselines 0; cal_done 0; debounce counters 0.
- Reset is honoured mid-measurement; the pad returns to grounded immediately.
- cap_in passes through a 2-flop synchronizer. The resulting fixed 2-cycle offset is cancelled by the baseline.
- Unselected pads are always grounded (cap_oe=1).
- IDLE: when enable=1, go to DISCHARGE on the next cycle with ch=0.
- DISCHARGE: cap_oe[ch]=1 for exactly DISCHARGE_CYC cycles, then MEASURE.
- MEASURE: cap_oe[ch]=0. Count is 0 on the first MEASURE cycle and increments each cycle.
  - Exit when synced cap_in[ch]=1 or count==TIMEOUT; the count is captured at exit.
  - If synced cap_in[ch] is already 1 on the first cycle, the count is 0.
- EVAL (1 cycle): sample_valid=1, sample_ch=ch, sample_cnt=captured count. Decision, in order:
  - If count==TIMEOUT: sample ignored for touch and baseline; debounce unchanged.
  - Else if cal_done[ch]=0: baseline[ch]<=count, cal_done[ch]<=1; touch unchanged.
  - Else candidate state:
    - Touch-candidate if touch[ch]=0 and count > baseline+THRESH.
    - Release-candidate if touch[ch]=1 and count < baseline+THRESH/2.
    - Sums are computed at CNT_W+1 bits (no wrap).
  - Candidate present: debounce counter increments; at DEB_N, touch[ch] toggles and the counter clears.
  - No candidate: debounce counter clears.
- After EVAL: ch advances, wrapping N_CH-1 -> 0.
  - If enable=0, go to IDLE (ch retained); else go to DISCHARGE.
  - enable dropping mid-channel finishes that channel first.
- Scan period per channel = DISCHARGE_CYC + (count+1) + 1 cycles.
- touch changes only on the cycle after an EVAL.

Optional Feature:
- CAP_BASELINE_TRACK_EN defined:
  - In EVAL, for a non-timeout sample where cal_done=1, touch[ch]=0 and there is no candidate, baseline[ch] moves 1 count toward the sample (clamped, never overshoots).
  - Baseline is frozen while touched.
- Undefined: the baseline is fixed from the first valid sample after reset.

Decomposition:
- Package cap_scan_pkg: state enum (IDLE, DISCHARGE, MEASURE, EVAL), default parameter constants, helper function for sample_ch width.
- Sub-module cap_in_sync: parameterised N-bit 2-flop synchronizer with async active-high reset to 0.
- Baseline and debounce arrays stay in the top of the block.

Test Plan:
- Reset then enable=1, pad 0 model rises 100 cycles after release:
  - cap_oe[0]=1 for 16 cycles, then 0.
  - sample_valid with sample_ch=0, sample_cnt=101 (includes sync offset); baseline loaded; touch=0.
- Pad 1 calibrated at 100, then 3 scans at 150:
  - touch[1] sets after the 3rd EVAL.
  - Scans at 130 (between 120 and 140) keep it set.
  - 3 scans at 110 clear it.
- Alternating 150/100 samples on pad 2: debounce never reaches 3; touch[2] stays 0.
- Pad 3 stuck low: sample_cnt=4095, touch and baseline unchanged; the next channel proceeds normally.
- enable deasserted during MEASURE of ch 1:
  - Ch 1 EVAL still pulses, then IDLE with all cap_oe=1.
  - Re-enable resumes at ch 2.
- With CAP_BASELINE_TRACK_EN: baseline 100 plus steady samples of 110 gives baseline 110 after 10 scans, no touch. Without the macro, baseline stays at 100.

Source files
------------

// File: rtl/cap_scan_pkg.sv
// Shared types and defaults for the multi-pad capacitive-touch scanner.
package cap_scan_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISCHARGE = 2'd1,
    MEASURE   = 2'd2,
    EVAL      = 2'd3
  } state_t;

  localparam int DEF_N_CH          = 4;
  localparam int DEF_CNT_W         = 12;
  localparam int DEF_DISCHARGE_CYC = 16;
  localparam int DEF_TIMEOUT       = 4095;
  localparam int DEF_THRESH        = 40;
  localparam int DEF_DEB_N         = 3;

  // Channel index width; a single-pad build still gets a 1-bit index.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cap_in_sync.sv
// N-bit two-flop synchronizer for asynchronous pad levels.
module cap_in_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_p0;

  // Two flop stages; reset clears both so a grounded pad reads 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      q       <= '0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/cap_scan_sched.sv
// Time-multiplexed capacitive-touch scanner: discharges each pad, times its
// charge-up through the external pull-up, and debounces the comparison of
// that count against a per-pad baseline into touch flags.
// Optional: define CAP_BASELINE_TRACK_EN to let an untouched pad's baseline
// drift one count per scan toward quiet samples.
module cap_scan_sched
  import cap_scan_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int DISCHARGE_CYC = DEF_DISCHARGE_CYC,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int THRESH        = DEF_THRESH,
  parameter int DEB_N         = DEF_DEB_N
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_CH-1:0]         cap_in,
  output logic [N_CH-1:0]         cap_out,
  output logic [N_CH-1:0]         cap_oe,
  output logic [N_CH-1:0]         touch,
  output logic                    sample_valid,
  output logic [ch_w(N_CH)-1:0]   sample_ch,
  output logic [CNT_W-1:0]        sample_cnt
);

  localparam int CH_W = ch_w(N_CH);
  localparam int DC_W = $clog2(DISCHARGE_CYC + 1);
  localparam int DB_W = $clog2(DEB_N + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  // Threshold level at one extra bit so baseline + delta never wraps.
  function automatic logic [CNT_W:0] level_add(input logic [CNT_W-1:0] b, input int delta);
    return {1'b0, b} + (CNT_W+1)'(delta);
  endfunction

`ifdef CAP_BASELINE_TRACK_EN
  // One-count step toward the sample; equal values leave the baseline alone.
  function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] b,
                                                   input logic [CNT_W-1:0] s);
    if (s > b) return b + 1'b1;
    else if (s < b) return b - 1'b1;
    else return b;
  endfunction
`endif

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch;
  logic [DC_W-1:0]   dcnt;
  logic [CNT_W-1:0]  cnt;
  logic [N_CH-1:0]   cap_sync;
  logic              meas_done;
  logic [CNT_W-1:0]  baseline [N_CH];
  logic [N_CH-1:0]   cal_done;
  logic [DB_W-1:0]   deb [N_CH];
  logic [CNT_W:0]    hi_lvl, lo_lvl;
  logic              cand;

  assign cap_out = '0;

  cap_in_sync #(.W(N_CH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cap_in),
    .q     (cap_sync)
  );

  assign meas_done = (state == MEASURE) && (cap_sync[ch] || (cnt == TMO));

  // Next-state logic plus pad drive and sample strobe decode.
  always_comb begin
    state_nxt    = state;
    cap_oe       = '1;
    sample_valid = 1'b0;
    unique case (state)
      IDLE:      if (enable) state_nxt = DISCHARGE;
      DISCHARGE: if (dcnt == DC_W'(DISCHARGE_CYC - 1)) state_nxt = MEASURE;
      MEASURE: begin
        cap_oe[ch] = 1'b0;
        if (meas_done) state_nxt = EVAL;
      end
      EVAL: begin
        sample_valid = 1'b1;
        state_nxt    = enable ? DISCHARGE : IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // State register, channel pointer, phase counters and sample capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ch         <= '0;
      dcnt       <= '0;
      cnt        <= '0;
      sample_ch  <= '0;
      sample_cnt <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= (state == DISCHARGE) ? dcnt + 1'b1 : '0;
      cnt   <= (state == MEASURE && !meas_done) ? cnt + 1'b1 : '0;
      if (meas_done) begin
        sample_ch  <= ch;
        sample_cnt <= cnt;
      end
      if (state == EVAL) ch <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
    end
  end

  // Candidate decision for the channel under evaluation.
  always_comb begin
    hi_lvl = level_add(baseline[ch], THRESH);
    lo_lvl = level_add(baseline[ch], THRESH / 2);
    cand   = touch[ch] ? ({1'b0, sample_cnt} < lo_lvl)
                       : ({1'b0, sample_cnt} > hi_lvl);
  end

  // Calibration, debounce and touch flag update, once per EVAL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        baseline[i] <= '0;
        deb[i]      <= '0;
      end
      cal_done <= '0;
      touch    <= '0;
    end else if (state == EVAL && sample_cnt != TMO) begin
      if (!cal_done[ch]) begin
        baseline[ch] <= sample_cnt;
        cal_done[ch] <= 1'b1;
      end else if (cand) begin
        if (deb[ch] == DB_W'(DEB_N - 1)) begin
          deb[ch]   <= '0;
          touch[ch] <= ~touch[ch];
        end else begin
          deb[ch] <= deb[ch] + 1'b1;
        end
      end else begin
        deb[ch] <= '0;
`ifdef CAP_BASELINE_TRACK_EN
        if (!touch[ch]) baseline[ch] <= step_toward(baseline[ch], sample_cnt);
`endif
      end
    end
  end

endmodule

// File: tb/tb_cap_scan_sched.sv
// Self-checking bench for cap_scan_sched: pad RC model, table of scans with
// hand-derived expectations, enable/reset corner sequences and a randomized
// phase checked against a per-pad behavioural model.
module tb_cap_scan_sched;

  localparam int N       = 4;
  localparam int TIMEOUT = 4095;
  localparam int THRESH  = 40;
  localparam int DEB_N   = 3;
`ifdef CAP_BASELINE_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] cap_in;
  logic [N-1:0] cap_out, cap_oe, touch;
  logic         sample_valid;
  logic [1:0]   sample_ch;
  logic [11:0]  sample_cnt;

  cap_scan_sched dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cap_in       (cap_in),
    .cap_out      (cap_out),
    .cap_oe       (cap_oe),
    .touch        (touch),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_cnt   (sample_cnt)
  );

  always #5 clk = ~clk;

  // Pad model: rise[i] cycles after release the pad reads high (-1 = never).
  int rise [N];
  int rel  [N];
  initial begin
    cap_in = '0;
    for (int i = 0; i < N; i++) begin rise[i] = -1; rel[i] = 0; end
  end
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (cap_oe[i] !== 1'b0) rel[i] = 0;
      else rel[i] = rel[i] + 1;
      cap_in[i] = (rise[i] >= 0) && (rel[i] >= rise[i]);
    end
  end

  int checks = 0;
  int failures = 0;

  // Behavioural per-pad model state.
  int m_ch;
  int m_base [N];
  bit m_cal  [N];
  int m_deb  [N];
  bit m_touch[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [N-1:0] model_touch();
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) t[i] = m_touch[i];
    return t;
  endfunction

  task automatic model_reset();
    m_ch = 0;
    for (int i = 0; i < N; i++) begin
      m_base[i] = 0; m_cal[i] = 0; m_deb[i] = 0; m_touch[i] = 0;
    end
  endtask

  // One channel scan: c = expected count (>=2), -1 = stuck pad. exp_t < 0 skips the table check.
  task automatic do_scan(input int c, input int exp_t);
    int chn, exp_cnt, cyc;
    bit seen_meas, cand;
    logic [N-1:0] mask;
    chn = m_ch;
    rise[chn] = (c < 0) ? -1 : c - 1;
    exp_cnt = (c < 0) ? TIMEOUT : c;
    mask = 4'b0001 << chn;
    mask = ~mask;
    cyc = 0;
    seen_meas = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!seen_meas && cap_oe !== 4'hF) begin
        seen_meas = 1;
        check("oe_select", cap_oe, mask);
      end
    end while (sample_valid !== 1'b1 && cyc < 6000);
    if (sample_valid !== 1'b1) begin
      failures++;
      $display("FAIL scan_timeout: no sample_valid for ch %0d after %0d cycles", chn, cyc);
      finish_now();
    end
    check("sample_ch", sample_ch, chn);
    check("sample_cnt", sample_cnt, exp_cnt);
    check("touch_pre_eval", touch, model_touch());
    if (exp_cnt != TIMEOUT) begin
      if (!m_cal[chn]) begin
        m_base[chn] = exp_cnt;
        m_cal[chn] = 1;
      end else begin
        cand = m_touch[chn] ? (exp_cnt < m_base[chn] + THRESH / 2)
                            : (exp_cnt > m_base[chn] + THRESH);
        if (cand) begin
          m_deb[chn]++;
          if (m_deb[chn] == DEB_N) begin m_touch[chn] = !m_touch[chn]; m_deb[chn] = 0; end
        end else begin
          m_deb[chn] = 0;
          if (TRACK && !m_touch[chn])
            m_base[chn] += (exp_cnt > m_base[chn]) ? 1 : ((exp_cnt < m_base[chn]) ? -1 : 0);
        end
      end
    end
    @(negedge clk);
    check("touch_post_eval", touch, model_touch());
    if (exp_t >= 0) check("touch_table", touch[chn], exp_t);
    m_ch = (m_ch + 1) % N;
  endtask

  typedef struct {
    int cnt;
    int exp_t;
  } vec_t;
  vec_t tbl [36];

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ones, stuck_n, c, base, idle_bad;
    int trk_val [N];

    tbl = '{
      '{101,0}, '{100,0}, '{100,0}, '{ -1,0},
      '{101,0}, '{150,0}, '{150,0}, '{ 80,0},
      '{101,0}, '{150,0}, '{100,0}, '{ -1,0},
      '{101,0}, '{150,1}, '{150,0}, '{125,0},
      '{101,0}, '{130,1}, '{100,0}, '{125,0},
      '{101,0}, '{130,1}, '{150,0}, '{ -1,0},
      '{101,0}, '{110,1}, '{100,0}, '{125,1},
      '{101,0}, '{110,1}, '{150,0}, '{ 60,1},
      '{101,0}, '{110,0}, '{100,0}, '{ 60,1}
    };

    model_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cap_oe", cap_oe, 4'hF);
    check("rst_cap_out", cap_out, 4'h0);
    check("rst_touch", touch, 4'h0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_sample_ch", sample_ch, 0);
    check("rst_sample_cnt", sample_cnt, 0);

    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_cap_oe", cap_oe, 4'hF);
    check("idle_valid", sample_valid, 1'b0);

    // First scan: pad 0 rises 100 cycles after release, discharge length checked.
    rise[0] = 100;
    enable = 1'b1;
    ones = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cap_oe[0] === 1'b1) ones++;
    end while (cap_oe[0] === 1'b1 && cyc < 100);
    check("discharge_len", ones, 16);

    for (int i = 0; i < 36; i++) do_scan(tbl[i].cnt, tbl[i].exp_t);

    // enable dropped during MEASURE of ch 1: finish ch 1, idle, resume at ch 2.
    do_scan(101, 0);
    rise[1] = 109;
    cyc = 0;
    while (cap_oe[1] !== 1'b0 && cyc < 200) begin @(negedge clk); cyc++; end
    check("reach_measure_ch1", cap_oe[1], 1'b0);
    enable = 1'b0;
    do_scan(110, 0);
    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cap_oe !== 4'hF || sample_valid !== 1'b0) idle_bad++;
    end
    check("idle_after_disable", idle_bad, 0);
    enable = 1'b1;
    do_scan(100, 0);

    // Baseline tracking: steady quiet samples, then a probe that only a fixed baseline sees as touch.
    trk_val = '{101, 110, 110, 110};
    for (int i = 0; i < 10 * N; i++) do_scan(trk_val[m_ch], -1);
    trk_val = '{101, 110, 145, 110};
    for (int i = 0; i < 3 * N; i++) do_scan(trk_val[m_ch], -1);
    check("track_probe_touch2", touch[2], TRACK ? 1'b0 : 1'b1);

    // Randomized scans against the model.
    stuck_n = 0;
    for (int i = 0; i < 40; i++) begin
      base = m_cal[m_ch] ? m_base[m_ch] : 100;
      c = base + int'($urandom_range(0, 100)) - 30;
      if (c < 2) c = 2;
      if (c > 3000) c = 3000;
      if (stuck_n < 2 && $urandom_range(0, 24) == 0) begin
        c = -1;
        stuck_n++;
      end
      do_scan(c, -1);
    end

    // Reset mid-measurement grounds the pad at once.
    cyc = 0;
    while (cap_oe === 4'hF && cyc < 200) begin @(negedge clk); cyc++; end
    check("reach_measure_final", (cap_oe !== 4'hF), 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_cap_oe", cap_oe, 4'hF);
    check("midrst_touch", touch, 4'h0);
    check("midrst_sample_cnt", sample_cnt, 0);
    check("midrst_valid", sample_valid, 1'b0);

    finish_now();
  end

endmodule
